mix_state_checker: RTL and testbench

//  Consumer/checker for the 8-lane 32-bit mixing-state stream. It runs a golden copy of
//  the per-clock mix round, accepts one observed state vector per handshake, and compares
//  it lane-by-lane against the expected vector. Match/error counts and per-lane error

---
 rtl/mix_pkg.sv | 35 +++
 rtl/mix_stage.sv | 41 ++++
 rtl/mix_state_checker.sv | 166 ++++++++++++++++
 tb/tb_mix_state_checker.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mix_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mix_pkg                                                         |
// | Brief    : Shared types and constants for the 8-lane 32-bit mix round      |
// |            and its checker.                                                |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package mix_pkg;

    localparam int NLANES  = 8;
    localparam int NSTAGES = 8;

    typedef logic [31:0]            lane_t;
    typedef lane_t [NLANES-1:0]     state_t;

    // Stage 6 / stage 7 per-lane multiply-add coefficients, index = lane
    localparam lane_t A6 [NLANES] = '{32'd2, 32'd3, 32'd5, 32'd7, 32'd11, 32'd13, 32'd17, 32'd19};
    localparam lane_t B6 [NLANES] = '{32'd3, 32'd5, 32'd7, 32'd11, 32'd13, 32'd17, 32'd19, 32'd23};
    localparam lane_t A7 [NLANES] = '{32'd2, 32'd3, 32'd3, 32'd3, 32'd5, 32'd13, 32'd35, 32'd87};
    localparam lane_t B7 [NLANES] = '{32'd0, 32'd1, 32'd8, 32'd27, 32'd64, 32'd125, 32'd216, 32'd343};

    localparam int SH_XOR = 16;
    localparam int SH_R1  = 17;
    localparam int SH_R2  = 12;

    // Seed vector: lane i holds i
    localparam state_t c_SEED = {32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1, 32'd0};

    // Neighbour lane index, wrapping modulo 8 (off may be negative)
    function automatic logic [2:0] lane_idx(input int lane, input int off);
        return 3'((lane + off) & 7);
    endfunction

endpackage : mix_pkg
`default_nettype wire

// File: rtl/mix_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mix_stage                                                       |
// | Brief    : Combinational single stage (S0..S7) of the mix round. Lanes     |
// |            update in order 0..7, so lane i sees lanes below i already      |
// |            updated within the same stage.                                  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module mix_stage
    import mix_pkg::*;
(
    input  state_t     i_state,
    input  logic [2:0] i_stage,
    output state_t     o_state
);

    state_t w_v;

    // Sequential lane chain: blocking updates on w_v give the in-stage forwarding
    always_comb begin
        w_v = i_state;
        for (int i = 0; i < NLANES; i++) begin
            case (i_stage)
                3'd0: w_v[i] = w_v[i] + lane_t'(i);
                3'd1: w_v[i] = w_v[i] + w_v[lane_idx(i, -1)];
                3'd2: w_v[i] = w_v[i] + w_v[lane_idx(i, 1)] - w_v[lane_idx(i, 5)];
                3'd3: w_v[i] = w_v[i] ^ (w_v[lane_idx(i, 3)] << SH_XOR);
                3'd4: w_v[i] = w_v[i] - (w_v[lane_idx(i, 2)] >> SH_R1)
                                      + (w_v[lane_idx(i, 4)] >> SH_R2);
                3'd5: w_v[i] = w_v[i] + w_v[lane_idx(i, -1)] - w_v[lane_idx(i, -2)];
                3'd6: w_v[i] = w_v[i] * A6[i] + B6[i];
                3'd7: w_v[i] = w_v[i] * A7[i] + B7[i];
                default: w_v[i] = w_v[i];
            endcase
        end
    end

    assign o_state = w_v;

endmodule : mix_stage
`default_nettype wire

// File: rtl/mix_state_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mix_state_checker                                               |
// | Brief    : Runs a golden mix round (one stage per clk) and compares each   |
// |            accepted 8-lane observed vector against it lane by lane.        |
// |            Optional macro MIX_CHK_CAPTURE_EN adds first-mismatch capture   |
// |            ports cap_valid / cap_got / cap_exp.                            |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module mix_state_checker
    import mix_pkg::*;
#(
    parameter int W     = 32,   // lane width; mix arithmetic is mod 2^32 so only 32 is meaningful
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [8*W-1:0]   in_data,
    output logic             busy,
    output logic             err_pulse,
    output logic [7:0]       err_lanes,
    output logic [CNT_W-1:0] ok_cnt,
    output logic [CNT_W-1:0] err_cnt
`ifdef MIX_CHK_CAPTURE_EN
    ,
    output logic             cap_valid,
    output logic [8*W-1:0]   cap_got,
    output logic [8*W-1:0]   cap_exp
`endif
);

    localparam logic [0:0] ST_COMPUTE = 1'b0;
    localparam logic [0:0] ST_WAIT    = 1'b1;

    logic [0:0]        r_state, w_state_nx;
    logic [2:0]        r_stage, w_stage_nx;
    logic              w_ready;
    logic              w_accept;
    state_t            r_exp;
    state_t            w_exp_stage;
    state_t            w_obs;
    logic [NLANES-1:0] w_mis;

    logic              r_err_pulse;
    logic [7:0]        r_err_lanes;
    logic [CNT_W-1:0]  r_ok_cnt;
    logic [CNT_W-1:0]  r_err_cnt;

    assign w_obs    = in_data;
    assign w_accept = in_valid & w_ready;

    mix_stage u_stage (
        .i_state (r_exp),
        .i_stage (r_stage),
        .o_state (w_exp_stage)
    );

    for (genvar g = 0; g < NLANES; g++) begin : g_lane
        assign w_mis[g] = (w_obs[g] != r_exp[g]);
    end

    // State and stage-counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_COMPUTE;
            r_stage <= 3'd0;
        end else begin
            r_state <= w_state_nx;
            r_stage <= w_stage_nx;
        end
    end

    // Next-state logic: eight compute clocks, then wait for one accepted vector
    always_comb begin
        w_state_nx = r_state;
        w_stage_nx = r_stage;
        w_ready    = 1'b0;
        case (r_state)
            ST_COMPUTE: begin
                w_stage_nx = r_stage + 3'd1;
                if (r_stage == 3'd7) begin
                    w_state_nx = ST_WAIT;
                end
            end
            ST_WAIT: begin
                w_ready = 1'b1;
                if (in_valid) begin
                    w_state_nx = ST_COMPUTE;
                    w_stage_nx = 3'd0;
                end
            end
            default: begin
                w_state_nx = ST_COMPUTE;
                w_stage_nx = 3'd0;
            end
        endcase
    end

    // Golden chain: advances from its own previous value, never from in_data
    always_ff @(posedge clk) begin
        if (rst) begin
            r_exp <= c_SEED;
        end else if (r_state == ST_COMPUTE) begin
            r_exp <= w_exp_stage;
        end
    end

    // Registered compare result, one-cycle pulse after each accept
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_pulse <= 1'b0;
            r_err_lanes <= 8'd0;
        end else begin
            r_err_pulse <= w_accept & (|w_mis);
            r_err_lanes <= w_accept ? w_mis : 8'd0;
        end
    end

    // Saturating match / mismatch counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ok_cnt  <= '0;
            r_err_cnt <= '0;
        end else if (w_accept) begin
            if (|w_mis) begin
                if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + CNT_W'(1);
            end else begin
                if (r_ok_cnt != '1) r_ok_cnt <= r_ok_cnt + CNT_W'(1);
            end
        end
    end

`ifdef MIX_CHK_CAPTURE_EN
    logic   r_cap_valid;
    state_t r_cap_got;
    state_t r_cap_exp;

    // First-mismatch capture, sticky until reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cap_valid <= 1'b0;
            r_cap_got   <= '0;
            r_cap_exp   <= '0;
        end else if (w_accept && (|w_mis) && !r_cap_valid) begin
            r_cap_valid <= 1'b1;
            r_cap_got   <= w_obs;
            r_cap_exp   <= r_exp;
        end
    end

    assign cap_valid = r_cap_valid;
    assign cap_got   = r_cap_got;
    assign cap_exp   = r_cap_exp;
`endif

    assign in_ready  = w_ready;
    assign busy      = ~w_ready;
    assign err_pulse = r_err_pulse;
    assign err_lanes = r_err_lanes;
    assign ok_cnt    = r_ok_cnt;
    assign err_cnt   = r_err_cnt;

endmodule : mix_state_checker
`default_nettype wire

// File: tb/tb_mix_state_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_mix_state_checker                                            |
// | Brief    : Directed self-checking bench for mix_state_checker. A second    |
// |            instance with CNT_W=2 shares the stimulus for saturation.       |
// |            Capture checks are active when MIX_CHK_CAPTURE_EN is defined.   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_mix_state_checker;
    import mix_pkg::*;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic [255:0] in_data = '0;

    logic         in_ready, busy, err_pulse;
    logic [7:0]   err_lanes;
    logic [15:0]  ok_cnt, err_cnt;
    logic         in_ready2, busy2, err_pulse2;
    logic [7:0]   err_lanes2;
    logic [1:0]   ok_cnt2, err_cnt2;
`ifdef MIX_CHK_CAPTURE_EN
    logic         cap_valid, cap_valid2;
    logic [255:0] cap_got, cap_exp, cap_got2, cap_exp2;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mix_state_checker #(.W(32), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .busy(busy), .err_pulse(err_pulse),
        .err_lanes(err_lanes), .ok_cnt(ok_cnt), .err_cnt(err_cnt)
`ifdef MIX_CHK_CAPTURE_EN
        , .cap_valid(cap_valid), .cap_got(cap_got), .cap_exp(cap_exp)
`endif
    );

    mix_state_checker #(.W(32), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .in_data(in_data), .busy(busy2), .err_pulse(err_pulse2),
        .err_lanes(err_lanes2), .ok_cnt(ok_cnt2), .err_cnt(err_cnt2)
`ifdef MIX_CHK_CAPTURE_EN
        , .cap_valid(cap_valid2), .cap_got(cap_got2), .cap_exp(cap_exp2)
`endif
    );

    // Independent reference of one full mix round (S0..S7)
    function automatic state_t ref_mix(input state_t s);
        logic [31:0] o  [8];
        logic [31:0] a6 [8];
        logic [31:0] b6 [8];
        logic [31:0] a7 [8];
        logic [31:0] b7 [8];
        state_t r;
        a6 = '{32'd2, 32'd3, 32'd5, 32'd7, 32'd11, 32'd13, 32'd17, 32'd19};
        b6 = '{32'd3, 32'd5, 32'd7, 32'd11, 32'd13, 32'd17, 32'd19, 32'd23};
        a7 = '{32'd2, 32'd3, 32'd3, 32'd3, 32'd5, 32'd13, 32'd35, 32'd87};
        b7 = '{32'd0, 32'd1, 32'd8, 32'd27, 32'd64, 32'd125, 32'd216, 32'd343};
        for (int k = 0; k < 8; k++) o[k] = s[k];
        for (int k = 0; k < 8; k++) o[k] = o[k] + 32'(k);
        for (int k = 0; k < 8; k++) o[k] = o[k] + o[(k+7)%8];
        for (int k = 0; k < 8; k++) o[k] = o[k] + o[(k+1)%8] - o[(k+5)%8];
        for (int k = 0; k < 8; k++) o[k] = o[k] ^ (o[(k+3)%8] << 16);
        for (int k = 0; k < 8; k++) o[k] = o[k] - (o[(k+2)%8] >> 17) + (o[(k+4)%8] >> 12);
        for (int k = 0; k < 8; k++) o[k] = o[k] + o[(k+7)%8] - o[(k+6)%8];
        for (int k = 0; k < 8; k++) o[k] = o[k] * a6[k] + b6[k];
        for (int k = 0; k < 8; k++) o[k] = o[k] * a7[k] + b7[k];
        for (int k = 0; k < 8; k++) r[k] = o[k];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) until in_ready is high; n = clocks waited
    task automatic wait_ready(output int n);
        n = 0;
        while (in_ready !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (in_ready !== 1'b1) chk("ready_timeout", 256'(in_ready), 256'd1);
    endtask

    // Present a vector, hold until accepted, sample registered result
    task automatic send(input state_t v, output int gap, output logic ep, output logic [7:0] el);
        in_data  = v;
        in_valid = 1'b1;
        wait_ready(gap);
        @(posedge clk); #1;
        ep = err_pulse;
        el = err_lanes;
    endtask

    task automatic hold_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin : main
        state_t     cur, v, bad2;
        int         n, gap, pulses, acc, cyc;
        logic       ep, any_err;
        logic [7:0] el;

        // ---------------- Test 1: reset + 100 clean vectors ----------------
        hold_reset();
        chk("rst_in_ready", 256'(in_ready), 256'd0);
        chk("rst_busy", 256'(busy), 256'd1);
        chk("rst_err_pulse", 256'(err_pulse), 256'd0);
        chk("rst_err_lanes", 256'(err_lanes), 256'd0);
        chk("rst_ok_cnt", 256'(ok_cnt), 256'd0);
        chk("rst_err_cnt", 256'(err_cnt), 256'd0);
`ifdef MIX_CHK_CAPTURE_EN
        chk("rst_cap_valid", 256'(cap_valid), 256'd0);
        chk("rst_cap_got", cap_got, 256'd0);
        chk("rst_cap_exp", cap_exp, 256'd0);
`endif
        rst = 1'b0;
        wait_ready(n);
        chk("t1_first_ready_clks", 256'(n), 256'd8);
        cur = c_SEED;
        any_err = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            cur = ref_mix(cur);
            send(cur, gap, ep, el);
            any_err |= ep;
            if (k == 2) chk("t1_gap", 256'(gap), 256'd8);
        end
        chk("t1_ok_cnt", 256'(ok_cnt), 256'd100);
        chk("t1_err_cnt", 256'(err_cnt), 256'd0);
        chk("t1_no_err_pulse", 256'(any_err), 256'd0);
        chk("t1_ok_cnt2_sat", 256'(ok_cnt2), 256'd3);

        // ---------------- Test 2: one corrupted vector (5) ----------------
        hold_reset();
        rst = 1'b0;
        cur = c_SEED;
        pulses = 0;
        for (int k = 1; k <= 20; k++) begin
            cur = ref_mix(cur);
            v = cur;
            if (k == 5) v[3][0] = ~v[3][0];
            send(v, gap, ep, el);
            if (ep) pulses++;
            if (k == 5) begin
                chk("t2_pulse", 256'(ep), 256'd1);
                chk("t2_lanes", 256'(el), 256'h08);
            end
            if (k == 6) chk("t2_lanes_clear", 256'(el), 256'd0);
        end
        chk("t2_pulses", 256'(pulses), 256'd1);
        chk("t2_err_cnt", 256'(err_cnt), 256'd1);
        chk("t2_ok_cnt", 256'(ok_cnt), 256'd19);

        // ---------------- Test 3: multi-lane error + capture ----------------
        hold_reset();
        rst = 1'b0;
        cur = c_SEED;
        bad2 = '0;
        for (int k = 1; k <= 4; k++) begin
            cur = ref_mix(cur);
            v = cur;
            if (k == 2) begin
                v[0] = v[0] ^ 32'hDEAD_0000;
                v[7] = v[7] ^ 32'h0000_0001;
                bad2 = v;
            end
            if (k == 4) v[1] = v[1] ^ 32'h0001_0000;
            send(v, gap, ep, el);
            if (k == 2) begin
                chk("t3_lanes_81", 256'(el), 256'h81);
`ifdef MIX_CHK_CAPTURE_EN
                chk("t3_cap_valid", 256'(cap_valid), 256'd1);
                chk("t3_cap_got", cap_got, 256'(bad2));
                chk("t3_cap_exp", cap_exp, 256'(cur));
`endif
            end
            if (k == 4) begin
                chk("t3_lanes_02", 256'(el), 256'h02);
`ifdef MIX_CHK_CAPTURE_EN
                chk("t3_cap_got_kept", cap_got, 256'(bad2));
                chk("t3_cap_valid_kept", 256'(cap_valid), 256'd1);
`endif
            end
        end
        chk("t3_err_cnt", 256'(err_cnt), 256'd2);

        // ---------------- Test 4: random in_valid, including while busy ----------------
        hold_reset();
        rst = 1'b0;
        cur = ref_mix(c_SEED);
        acc = 0;
        cyc = 0;
        any_err = 1'b0;
        while (acc < 100 && cyc < 5000) begin
            logic will_acc;
            in_data  = cur;
            in_valid = 1'($urandom_range(0, 1));
            will_acc = in_valid & in_ready;
            @(posedge clk); #1;
            cyc++;
            if (will_acc) begin
                acc++;
                any_err |= err_pulse;
                cur = ref_mix(cur);
            end
        end
        in_valid = 1'b0;
        chk("t4_accepts", 256'(acc), 256'd100);
        chk("t4_ok_cnt", 256'(ok_cnt), 256'd100);
        chk("t4_err_cnt", 256'(err_cnt), 256'd0);
        chk("t4_no_err_pulse", 256'(any_err), 256'd0);

        // ---------------- Test 5: reset at stage 4 of 3rd COMPUTE ----------------
        hold_reset();
        rst = 1'b0;
        cur = c_SEED;
        for (int k = 1; k <= 2; k++) begin
            cur = ref_mix(cur);
            send(cur, gap, ep, el);
        end
        in_valid = 1'b0;
        chk("t5_ok_before", 256'(ok_cnt), 256'd2);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("t5_ok_cleared", 256'(ok_cnt), 256'd0);
        chk("t5_err_cleared", 256'(err_cnt), 256'd0);
        chk("t5_not_ready", 256'(in_ready), 256'd0);
        wait_ready(n);
        chk("t5_ready_clks", 256'(n), 256'd8);
        cur = ref_mix(c_SEED);
        send(cur, gap, ep, el);
        chk("t5_seed_vec_ok", 256'(ep), 256'd0);
        chk("t5_ok_cnt", 256'(ok_cnt), 256'd1);

        // ---------------- Test 6: saturation with CNT_W=2 ----------------
        hold_reset();
        rst = 1'b0;
        cur = c_SEED;
        for (int k = 1; k <= 5; k++) begin
            cur = ref_mix(cur);
            v = cur;
            v[2] = v[2] ^ 32'h8000_0000;
            send(v, gap, ep, el);
            chk($sformatf("t6_err_cnt2_%0d", k), 256'(err_cnt2), 256'((k < 3) ? k : 3));
        end
        chk("t6_err_cnt_wide", 256'(err_cnt), 256'd5);
        chk("t6_ok_cnt2", 256'(ok_cnt2), 256'd0);
        chk("t6_lanes2", 256'(err_lanes2), 256'h04);

        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule : tb_mix_state_checker
`default_nettype wire
